// File: rtl/pcileech_cfg_rsp_pack_pkg.sv
// Shared definitions for the config-response packer: magic value,
// response type codes, FSM state encoding and small helpers.
package pcileech_cfg_rsp_pack_pkg;

    localparam logic [11:0] MAGIC = 12'h177;

    // Type code carried in lo[15:12] of a well-formed response.
    typedef enum logic [3:0] {
        STATUS    = 4'd0,
        CFG_READ  = 4'd1,
        CFG_WRITE = 4'd2,
        PHY_READ  = 4'd3
    } rsp_type_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_HI   = 3'd1,
        WAIT_HI = 3'd2,
        RD_LO   = 3'd3,
        WAIT_LO = 3'd4,
        CHECK   = 3'd5,
        OUT     = 3'd6
    } state_e;

    // A pair is accepted when the second DW carries the magic tag and a known type.
    function automatic logic lo_is_valid(input logic [31:0] lo);
        return (lo[11:0] == MAGIC) && (lo[15:12] <= PHY_READ);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcileech_cfg_rsp_pack.sv
// Packs pairs of DWs from the config-response FIFO into 64-bit responses.
// The second DW of a pair must carry the magic tag; if it does not, the
// stream is resynchronised by treating that DW as the start of a new pair.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for FIFO data and a free output register
// RD_HI   | read strobe for the first DW
// WAIT_HI | first DW arrives; capture into hi
// RD_LO   | read strobe for the second DW (timeout running)
// WAIT_LO | waiting for the second DW, re-polling the FIFO (timeout running)
// CHECK   | validate lo; emit or resync
// OUT     | response presented, count it
module pcileech_cfg_rsp_pack
    import pcileech_cfg_rsp_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_empty,
    output logic        rx_rd_en,
    output logic [63:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] cnt_pkt,
    output logic [15:0] cnt_drop
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic [15:0]   cnt_pkt_q, cnt_pkt_d;
    logic [15:0]   cnt_drop_q, cnt_drop_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          out_free;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            cnt_pkt_q  <= '0;
            cnt_drop_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            cnt_pkt_q  <= cnt_pkt_d;
            cnt_drop_q <= cnt_drop_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state, read strobe, pairing, timeout and output-register control.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        cnt_pkt_d  = cnt_pkt_q;
        cnt_drop_d = cnt_drop_q;
        tmo_d      = '0;
        rx_rd_en   = 1'b0;
        out_free   = ~m_valid_q | m_ready;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Only start a pair when its result has somewhere to go,
                // so a stalled consumer never causes a read.
                if (!rx_empty && out_free) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                rx_rd_en = ~rx_empty;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = rx_empty ? WAIT_LO : RD_LO;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_LO: begin
                rx_rd_en = ~rx_empty;
                tmo_d    = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TW'(1);
                state_d  = WAIT_LO;
            end
            WAIT_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = CHECK;
                end else if (tmo_q == TMO_LIMIT) begin
                    hi_d       = '0;
                    cnt_drop_d = sat_inc16(cnt_drop_q);
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (!rx_empty) begin
                        state_d = RD_LO;
                    end
                end
            end
            CHECK: begin
                if (lo_is_valid(lo_q)) begin
                    // Output register loads on entry to OUT so m_valid
                    // rises two cycles after the closing DW arrives.
                    m_data_d  = {hi_q, lo_q};
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    hi_d       = lo_q;
                    cnt_drop_d = sat_inc16(cnt_drop_q);
                    state_d    = rx_empty ? WAIT_LO : RD_LO;
                end
            end
            OUT: begin
                cnt_pkt_d = sat_inc16(cnt_pkt_q);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign cnt_pkt  = cnt_pkt_q;
    assign cnt_drop = cnt_drop_q;

endmodule

// File: tb/tb_pcileech_cfg_rsp_pack.sv
// Bench for pcileech_cfg_rsp_pack: FIFO model, DW-stream pairing model,
// per-cycle output scoreboard and directed scenarios.
module tb_pcileech_cfg_rsp_pack;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_empty;
    logic        rx_rd_en;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] cnt_pkt;
    logic [15:0] cnt_drop;

    pcileech_cfg_rsp_pack #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_empty (rx_empty),
        .rx_rd_en (rx_rd_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .cnt_pkt  (cnt_pkt),
        .cnt_drop (cnt_drop)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (ok) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // External FIFO: data and valid appear one cycle after the read strobe.
    logic [31:0] fifo_mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign rx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (rx_rd_en && !rx_empty) begin
            rx_data  <= fifo_mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
            rx_valid <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
        end
    end

    // Pairing model: works on whole DW bursts rather than cycles.
    logic [63:0] exp_q [$];
    logic [31:0] burst [$];
    int exp_pkt = 0;
    int exp_drop = 0;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Returns 1 if a lone first DW remains, which the DUT will time out.
    function automatic bit model_burst();
        bit have_hi = 0;
        logic [31:0] hi = '0;
        foreach (burst[i]) begin
            if (!have_hi) begin
                hi = burst[i];
                have_hi = 1;
            end else if (burst[i][11:0] == 12'h177 && burst[i][15:12] < 4'd4) begin
                exp_q.push_back({hi, burst[i]});
                exp_pkt = sat(exp_pkt + 1);
                have_hi = 0;
            end else begin
                exp_drop = sat(exp_drop + 1);
                hi = burst[i];
            end
        end
        if (have_hi) exp_drop = sat(exp_drop + 1);
        return have_hi;
    endfunction

    task automatic push_raw();
        foreach (burst[i]) fifo_mem[(wr_ptr + i) % 256] = burst[i];
        wr_ptr = wr_ptr + burst.size();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle scoreboard and observation counters.
    int cyc = 0;
    int last_rxv = 0;
    int mv_rise = 0;
    int mv_cycles = 0;
    int rd_cycles = 0;
    int n_acc = 0;
    bit mv_prev = 0;
    bit hold_prev = 0;
    logic [63:0] hold_data = '0;
    logic [63:0] last_acc = '0;

    // Compare DUT outputs against the model on every meaningful cycle.
    always @(negedge clk) begin
        if (rst) begin
            mv_prev = 0;
            hold_prev = 0;
        end else begin
            cyc++;
            if (rx_valid) last_rxv = cyc;
            if (m_valid && !mv_prev) mv_rise = cyc;
            if (m_valid) mv_cycles++;
            if (rx_rd_en) rd_cycles++;
            if (hold_prev) chk(m_valid && m_data == hold_data, "hold_stable", m_data, hold_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_out", m_data, 64'h0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk(m_data == e, "out_data", m_data, e);
                end
                last_acc = m_data;
                n_acc++;
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            mv_prev = m_valid;
        end
    end

    task automatic drain(input bit leftover, input bit rand_ready);
        int n = 0;
        while ((exp_q.size() != 0 || !rx_empty) && n < 3000) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        m_ready = 1'b1;
        chk(n < 3000, "drain_bound", 64'(n), 64'd3000);
        cycles(leftover ? TIMEOUT + 20 : 10);
        chk(cnt_pkt == 16'(exp_pkt), "cnt_pkt_model", 64'(cnt_pkt), 64'(exp_pkt));
        chk(cnt_drop == 16'(exp_drop), "cnt_drop_model", 64'(cnt_drop), 64'(exp_drop));
    endtask

    task automatic send(input bit rand_ready);
        bit lo_left;
        lo_left = model_burst();
        push_raw();
        drain(lo_left, rand_ready);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rd0;
        int acc0;
        rst = 1'b1;
        m_ready = 1'b1;
        cycles(3);
        chk(m_valid == 1'b0, "rst_m_valid", 64'(m_valid), 64'd0);
        chk(m_data == 64'd0, "rst_m_data", m_data, 64'd0);
        chk(cnt_pkt == 16'd0, "rst_cnt_pkt", 64'(cnt_pkt), 64'd0);
        chk(cnt_drop == 16'd0, "rst_cnt_drop", 64'(cnt_drop), 64'd0);
        chk(rx_rd_en == 1'b0, "rst_rd_en", 64'(rx_rd_en), 64'd0);
        rst = 1'b0;
        cycles(2);

        // Basic pair.
        mv_cycles = 0;
        burst = '{32'hAABBCCDD, 32'h00001177};
        send(0);
        chk(last_acc == 64'hAABBCCDD_00001177, "pair_data", last_acc, 64'hAABBCCDD_00001177);
        chk(cnt_pkt == 16'd1, "pair_cnt_pkt", 64'(cnt_pkt), 64'd1);
        chk(mv_cycles == 1, "pair_valid_len", 64'(mv_cycles), 64'd1);
        chk(mv_rise - last_rxv == 2, "pair_latency", 64'(mv_rise - last_rxv), 64'd2);

        // Resync on a bad second DW.
        burst = '{32'h12345678, 32'hDEADBEEF, 32'h00003177};
        send(0);
        chk(last_acc == 64'hDEADBEEF_00003177, "resync_data", last_acc, 64'hDEADBEEF_00003177);
        chk(cnt_pkt == 16'd2, "resync_cnt_pkt", 64'(cnt_pkt), 64'd2);
        chk(cnt_drop == 16'd1, "resync_cnt_drop", 64'(cnt_drop), 64'd1);

        // Type-code boundaries (4 rejected, 0 and 3 accepted) and wrong magic.
        burst = '{32'hCAFE0001, 32'h00004177, 32'h00000177,
                  32'h00002177, 32'h12340177,
                  32'h11113177, 32'h00000176, 32'h00003177};
        send(0);
        chk(cnt_pkt == 16'd5, "type_cnt_pkt", 64'(cnt_pkt), 64'd5);
        chk(cnt_drop == 16'd3, "type_cnt_drop", 64'(cnt_drop), 64'd3);

        // Back-pressure: three pairs queued, consumer stalled.
        m_ready = 1'b0;
        burst = '{32'hA0000001, 32'h00000177, 32'hA0000002, 32'h00001177,
                  32'hA0000003, 32'h00002177};
        void'(model_burst());
        acc0 = n_acc;
        push_raw();
        cycles(20);
        rd0 = rd_cycles;
        cycles(50);
        chk(rd_cycles == rd0, "bp_no_read", 64'(rd_cycles), 64'(rd0));
        chk(m_valid == 1'b1, "bp_valid_held", 64'(m_valid), 64'd1);
        chk(m_data == 64'hA0000001_00000177, "bp_head", m_data, 64'hA0000001_00000177);
        chk(n_acc == acc0, "bp_no_accept", 64'(n_acc), 64'(acc0));
        m_ready = 1'b1;
        drain(0, 0);
        chk(last_acc == 64'hA0000003_00002177, "bp_last", last_acc, 64'hA0000003_00002177);

        // Random consumer readiness.
        burst = '{32'hB0000001, 32'h00000177, 32'hB0000002, 32'h00003177,
                  32'hB0000003, 32'h00001177, 32'hB0000004, 32'h00002177};
        send(1);

        // Timeout on a lone first DW.
        burst = '{32'h11111111};
        void'(model_burst());
        acc0 = n_acc;
        push_raw();
        cycles(200);
        chk(cnt_drop == 16'd3, "tmo_before", 64'(cnt_drop), 64'd3);
        cycles(100);
        chk(cnt_drop == 16'd4, "tmo_after", 64'(cnt_drop), 64'd4);
        chk(n_acc == acc0, "tmo_no_out", 64'(n_acc), 64'(acc0));
        burst = '{32'h55555555, 32'h00001177};
        send(0);
        chk(last_acc == 64'h55555555_00001177, "tmo_next_pair", last_acc, 64'h55555555_00001177);

        // Asynchronous reset while waiting for the second DW.
        burst = '{32'h77777777};
        push_raw();
        cycles(10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(m_valid == 1'b0, "arst_m_valid", 64'(m_valid), 64'd0);
        chk(m_data == 64'd0, "arst_m_data", m_data, 64'd0);
        chk(cnt_pkt == 16'd0, "arst_cnt_pkt", 64'(cnt_pkt), 64'd0);
        chk(cnt_drop == 16'd0, "arst_cnt_drop", 64'(cnt_drop), 64'd0);
        chk(rx_rd_en == 1'b0, "arst_rd_en", 64'(rx_rd_en), 64'd0);
        exp_q.delete();
        exp_pkt = 0;
        exp_drop = 0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        burst = '{32'hCCCC0000, 32'h00002177};
        send(0);
        chk(last_acc == 64'hCCCC0000_00002177, "arst_next_pair", last_acc, 64'hCCCC0000_00002177);
        chk(cnt_pkt == 16'd1, "arst_cnt_pkt_after", 64'(cnt_pkt), 64'd1);
        chk(cnt_drop == 16'd0, "arst_cnt_drop_after", 64'(cnt_drop), 64'd0);

        // Drop-counter saturation.
        force dut.cnt_drop_q = 16'hFFFE;
        cycles(1);
        release dut.cnt_drop_q;
        cycles(1);
        exp_drop = 16'hFFFE;
        chk(cnt_drop == 16'hFFFE, "sat_preload", 64'(cnt_drop), 64'hFFFE);
        burst = '{32'h00000000, 32'h00000001, 32'h00000002};
        send(0);
        chk(cnt_drop == 16'hFFFF, "sat_cnt_drop", 64'(cnt_drop), 64'hFFFF);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
